// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
// Serial receive stage: deframes start / DATA_W data bits (LSB first) / odd
// parity / stop, flags parity and framing errors, and presents the word in a
// single-entry output buffer with a valid/ready handshake. A frame that
// completes while the buffer is occupied and not being drained is dropped and
// recorded in a sticky overflow flag.
// ---------------------------------------------------------------------------
module parity_frame_checker #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_frm_err,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Expected odd-parity bit: set when the data holds an even number of ones.
  function automatic logic f_odd_par(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_par_err;
  logic                r_frm_err;
  logic                r_overflow;
  logic                r_busy;

  logic                w_frame_done;
  logic                w_buf_free;
  logic                w_exp_par;

  // Frame completion, buffer availability and expected parity of the shifted word.
  always_comb begin
    w_frame_done = 1'b0;
    w_buf_free   = 1'b0;
    w_exp_par    = f_odd_par(r_shift);
    if (r_state == ST_STOP) begin
      w_frame_done = bit_valid;
    end else begin
      w_frame_done = 1'b0;
    end
    if (!r_out_valid || out_ready) begin
      w_buf_free = 1'b1;
    end else begin
      w_buf_free = 1'b0;
    end
  end

  // Deframing FSM, registered busy decode and the single-entry output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_shift     <= {DATA_W{1'b0}};
      r_par       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_par_err   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Bit-level state advance happens only on sampled bits.
      if (bit_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (!bit_in) begin
              r_state <= ST_DATA;
              r_cnt   <= {CNT_W{1'b0}};
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          ST_DATA: begin
            r_shift[r_cnt] <= bit_in;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_PARITY;
            end else begin
              r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            r_busy <= 1'b1;
          end
          ST_PARITY: begin
            r_par   <= bit_in;
            r_state <= ST_STOP;
            r_busy  <= 1'b1;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else begin
        r_state <= r_state;
      end

      // Load a completed frame if the buffer is free this cycle, else drop it.
      if (w_frame_done) begin
        if (w_buf_free) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_shift;
          r_par_err   <= (r_par != w_exp_par);
          r_frm_err   <= ~bit_in;
        end else begin
          r_overflow  <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_par_err = r_par_err;
  assign out_frm_err = r_frm_err;
  assign overflow    = r_overflow;
  assign busy        = r_busy;

endmodule

// File: tb/tb_parity_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_checker
// Directed-vector bench for parity_frame_checker with hand-computed results.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_parity_frame_checker;

  logic       clk;
  logic       rst_n;
  logic       bit_valid;
  logic       bit_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_par_err;
  logic       out_frm_err;
  logic       overflow;
  logic       busy;

  int n_tests;
  int n_fail;

  parity_frame_checker #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_par_err (out_par_err),
    .out_frm_err (out_frm_err),
    .overflow    (overflow),
    .busy        (busy)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sampled bit for one cycle, optionally preceded by idle cycles.
  task automatic drive_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bit_valid = 1'b0;
      bit_in    = ~b;
      tick();
    end
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  // Full frame: start, 8 data bits LSB first, parity, stop. ready_on_stop raises
  // out_ready only during the stop-bit cycle; gap_seed>0 inserts idle cycles.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic ready_on_stop, input int gap_seed);
    drive_bit(1'b0, gap_seed % 3);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], (gap_seed > 0) ? ((i * 7 + gap_seed) % 4) : 0);
    end
    drive_bit(par, (gap_seed > 0) ? 2 : 0);
    if (ready_on_stop) out_ready = 1'b1;
    drive_bit(stp, (gap_seed > 0) ? 1 : 0);
    out_ready = 1'b0;
  endtask

  // Accept the buffered frame with a one-cycle ready pulse.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check(tag, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
    check({tag, "_par"}, {31'd0, out_par_err}, {31'd0, pe});
    check({tag, "_frm"}, {31'd0, out_frm_err}, {31'd0, fe});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, out_data}, 32'd0);
    check({tag, "_par"}, {31'd0, out_par_err}, 32'd0);
    check({tag, "_frm"}, {31'd0, out_frm_err}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    out_ready = 1'b0;
    tick();
    apply_reset();

    // 1: basic frame 0xA5 (4 ones -> parity bit 1).
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0);
    check_frame("t1", 8'hA5, 1'b0, 1'b0);
    tick();
    check("t1_hold", {24'd0, out_data}, 32'h0000_00A5);
    consume("t1_drain");

    // 2: wrong parity on 0xA5, then 0x07 (3 ones -> parity bit 0).
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
    check_frame("t2a", 8'hA5, 1'b1, 1'b0);
    consume("t2a_drain");
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 0);
    check_frame("t2b", 8'h07, 1'b0, 1'b0);
    consume("t2b_drain");

    // 3: framing error on 0x3C, then a clean 0x96.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    check_frame("t3a", 8'h3C, 1'b0, 1'b1);
    consume("t3a_drain");
    send_frame(8'h96, 1'b1, 1'b1, 1'b0, 0);
    check_frame("t3b", 8'h96, 1'b0, 1'b0);
    consume("t3b_drain");

    // 4: overflow with out_ready low.
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 0);
    check("t4_first_valid", {31'd0, out_valid}, 32'd1);
    check("t4_no_ovf", {31'd0, overflow}, 32'd0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 0);
    check("t4_keep", {24'd0, out_data}, 32'h0000_0011);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    consume("t4_drain");
    check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 5: drain and refill in the same cycle.
    apply_reset();
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 0);
    check("t5_first", {24'd0, out_data}, 32'h0000_0011);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 0);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    check("t5_data", {24'd0, out_data}, 32'h0000_0022);
    check("t5_ovf", {31'd0, overflow}, 32'd0);
    consume("t5_drain");

    // 6a: gaps inside a 0x5A frame (4 ones -> parity bit 1).
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 5);
    check_frame("t6a", 8'h5A, 1'b0, 1'b0);
    consume("t6a_drain");

    // 6b: reset mid-DATA while a frame is buffered.
    send_frame(8'h33, 1'b1, 1'b1, 1'b0, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    check("t6b_busy", {31'd0, busy}, 32'd1);
    apply_reset();
    // Idle-line bits after reset must not start a frame.
    drive_bit(1'b1, 0);
    check("t6b_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0);
    check_frame("t6b", 8'h5A, 1'b0, 1'b0);
    consume("t6b_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
